int_add_sub_pipe: RTL and testbench

Parametrised, pipelined integer adder/subtractor for the ALU datapath, successor to the combinational add/sub unit. Adds configurable operand width, pipeline depth, saturating modes, a condition-flag output and a valid/ready handshake with backpressure, so it can sit between the issue stage and writeback at higher clock rates. A sideband tag travels with each operation so downstream logic can match results to requests.

---
 rtl/int_add_sub_pipe.sv | 98 +++++++++
 tb/tb_int_add_sub_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_add_sub_pipe.sv
// int_add_sub_pipe
//   Pipelined integer adder/subtractor with optional signed saturation,
//   condition flags, a sideband tag and valid/ready handshake.
//   All arithmetic happens combinationally ahead of stage 1. Stages 2..STAGES
//   only delay result/flags/tag/valid. A single global enable stalls every
//   stage when the last stage holds a valid result that downstream refuses.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   synchronous active-low reset
//   i_valid   operation presented          o_ready   operation accepted this cycle
//   i_mode    00 add, 01 sub, 10 sat add, 11 sat sub
//   i_a, i_b  two's complement operands     i_tag     sideband tag
//   o_valid   result available              i_ready   downstream accepts result
//   o_result  result                        o_tag     tag of o_result
//   o_flags   {carry, overflow, zero, negative}
module int_add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic [3:0]       o_flags
);

    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       flags_d;
    logic             en;
    logic             in_xfer;

    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][WIDTH-1:0]  res_pipe;
    logic [STAGES:1][TAG_W-1:0]  tag_pipe;
    logic [STAGES:1][3:0]        flg_pipe;

    // Subtract is a + ~b + 1; the carry-in comes from mode[0] so one adder
    // serves both operations.
    always_comb begin
        b_x     = i_b ^ {WIDTH{i_mode[0]}};
        sum     = {1'b0, i_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, i_mode[0]};
        ovf     = (i_a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != i_a[WIDTH-1]);
        res_d   = sum[WIDTH-1:0];
        // On signed overflow the true result has the sign of a, so clamp
        // toward that side.
        if (i_mode[1] && ovf)
            res_d = i_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        // carry/overflow are raw; zero/negative follow the final result.
        flags_d = {sum[WIDTH], ovf, (res_d == '0), res_d[WIDTH-1]};
    end

    // Whole pipe freezes only when the head holds a refused result; bubbles
    // are kept in place rather than collapsed.
    assign en      = !(vld_pipe[STAGES] && !i_ready);
    assign o_ready = en && i_rst_n;
    assign in_xfer = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            res_pipe <= '0;
            tag_pipe <= '0;
            flg_pipe <= '0;
        end else if (en) begin
            // Data of a bubble is don't-care, so load it unconditionally.
            vld_pipe[1] <= in_xfer;
            res_pipe[1] <= res_d;
            tag_pipe[1] <= i_tag;
            flg_pipe[1] <= flags_d;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                res_pipe[s] <= res_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
                flg_pipe[s] <= flg_pipe[s-1];
            end
        end
    end

    assign o_valid  = vld_pipe[STAGES];
    assign o_result = res_pipe[STAGES];
    assign o_tag    = tag_pipe[STAGES];
    assign o_flags  = flg_pipe[STAGES];

endmodule

// File: tb/tb_int_add_sub_pipe.sv
// Bench for int_add_sub_pipe: directed vectors and handshake sequences on a
// 32-bit/2-stage instance, random traffic on an 8-bit/4-stage instance.
module tb_int_add_sub_pipe;

    localparam int W1 = 32, S1 = 2, T1 = 5;
    localparam int W2 = 8,  S2 = 4, T2 = 4;
    localparam int NRND = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic          a_valid, a_ready, a_ov, a_iready;
    logic [1:0]    a_mode;
    logic [W1-1:0] a_a, a_b, a_res;
    logic [T1-1:0] a_tag, a_otag;
    logic [3:0]    a_flags;

    // 8-bit instance
    logic          r_valid, r_ready, r_ov, r_iready;
    logic [1:0]    r_mode;
    logic [W2-1:0] r_a, r_b, r_res;
    logic [T2-1:0] r_tag, r_otag;
    logic [3:0]    r_flags;

    int_add_sub_pipe #(.WIDTH(W1), .STAGES(S1), .TAG_W(T1)) u32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
        .i_mode(a_mode), .i_a(a_a), .i_b(a_b), .i_tag(a_tag),
        .o_valid(a_ov), .i_ready(a_iready), .o_result(a_res), .o_tag(a_otag),
        .o_flags(a_flags));

    int_add_sub_pipe #(.WIDTH(W2), .STAGES(S2), .TAG_W(T2)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(r_valid), .o_ready(r_ready),
        .i_mode(r_mode), .i_a(r_a), .i_b(r_b), .i_tag(r_tag),
        .o_valid(r_ov), .i_ready(r_iready), .o_result(r_res), .o_tag(r_otag),
        .o_flags(r_flags));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits, then range test for
    // overflow and unsigned compare/sum for carry.
    typedef longint unsigned u64_t;
    typedef struct {
        logic [63:0] res;
        logic [3:0]  fl;
    } ref_t;

    function automatic ref_t model(input int w, input logic [1:0] m,
                                   input u64_t a, input u64_t b);
        ref_t   r;
        longint one = 1;
        u64_t   mask = u64_t'((one <<< w) - 1);
        longint sa, sb, ex, mx, mn;
        logic   c, v;
        sa = a[w-1] ? longint'(a) - (one <<< w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (one <<< w) : longint'(b);
        mx = (one <<< (w-1)) - 1;
        mn = -(one <<< (w-1));
        if (m[0]) begin
            ex    = sa - sb;
            c     = (a >= b);
            r.res = (a - b) & mask;
        end else begin
            ex    = sa + sb;
            c     = ((a + b) > mask);
            r.res = (a + b) & mask;
        end
        v = (ex > mx) || (ex < mn);
        if (m[1] && v)
            r.res = (ex > mx) ? u64_t'(mx) : (u64_t'(mn) & mask);
        r.fl = {c, v, (r.res == 0), r.res[w-1]};
        return r;
    endfunction

    typedef struct {
        logic [1:0]  m;
        logic [31:0] a, b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[10];

    task automatic drive32(input logic [1:0] m, input logic [31:0] a,
                           input logic [31:0] b, input logic [T1-1:0] t);
        a_valid = 1'b1; a_mode = m; a_a = a; a_b = b; a_tag = t;
    endtask

    task automatic chk32(input string name, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [T1-1:0] t);
        ref_t e;
        e = model(W1, m, u64_t'(a), u64_t'(b));
        chk({name, "_vld"}, 64'(a_ov), 64'd1);
        chk({name, "_data"}, {20'd0, a_res, a_flags, 3'd0, a_otag},
            {20'd0, e.res[31:0], e.fl, 3'd0, t});
    endtask

    typedef struct {
        logic [W2-1:0] res;
        logic [3:0]    fl;
        logic [T2-1:0] tag;
    } exp8_t;

    exp8_t q[$];

    initial begin
        logic [31:0] ra[8], rb[8];
        logic [1:0]  rm[8];
        logic [31:0] held_res;
        exp8_t       e8, hold_v;
        ref_t        rr;
        logic        hold;
        int          sent, got, cyc;

        // {mode, a, b, expected result, expected {c,v,z,n}}
        vecs[0] = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
        vecs[1] = '{2'b10, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 4'b0100};
        vecs[2] = '{2'b01, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1010};
        vecs[3] = '{2'b01, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0001};
        vecs[4] = '{2'b11, 32'h80000000, 32'h00000001, 32'h80000000, 4'b1101};
        vecs[5] = '{2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
        vecs[6] = '{2'b11, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 4'b0100};
        vecs[7] = '{2'b10, 32'h80000000, 32'h80000000, 32'h80000000, 4'b1101};
        vecs[8] = '{2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 4'b1010};
        vecs[9] = '{2'b10, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000};

        a_valid = 0; a_mode = 0; a_a = 0; a_b = 0; a_tag = 0; a_iready = 1;
        r_valid = 0; r_mode = 0; r_a = 0; r_b = 0; r_tag = 0; r_iready = 1;

        // ---- reset state ----
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready32", 64'(a_ready), 64'd0);
        chk("rst_ready8", 64'(r_ready), 64'd0);
        chk("rst_out32", {27'd0, a_ov, a_res, a_flags}, 64'd0);
        chk("rst_tag32", 64'(a_otag), 64'd0);
        chk("rst_out8", {r_ov, r_res, r_flags, r_otag}, 64'd0);
        rst_n = 1;
        #1;
        chk("ready_after_rst", 64'(a_ready), 64'd1);

        // ---- directed vectors, one at a time, latency exactly S1 ----
        for (int i = 0; i < 10; i++) begin
            drive32(vecs[i].m, vecs[i].a, vecs[i].b, T1'(i));
            @(negedge clk);
            a_valid = 0;
            for (int k = 1; k < S1; k++) begin
                chk("vec_early_vld", 64'(a_ov), 64'd0);
                @(negedge clk);
            end
            chk($sformatf("vec%0d_vld", i), 64'(a_ov), 64'd1);
            chk($sformatf("vec%0d_res", i), 64'(a_res), 64'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i), 64'(a_flags), 64'(vecs[i].fl));
            chk($sformatf("vec%0d_tag", i), 64'(a_otag), 64'(i));
        end

        // ---- back-to-back 8 ops ----
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; rm[i] = 2'($urandom);
        end
        for (int c = 0; c < 8 + S1; c++) begin
            if (c >= S1)
                chk32($sformatf("b2b%0d", c - S1), rm[c-S1], ra[c-S1], rb[c-S1], T1'(c - S1));
            if (c < 8) drive32(rm[c], ra[c], rb[c], T1'(c));
            else       a_valid = 0;
            @(negedge clk);
        end
        chk("b2b_empty", 64'(a_ov), 64'd0);

        // ---- stall with full pipe, then drain with simultaneous in/out ----
        a_iready = 0;
        drive32(2'b00, ra[0], rb[0], 5'd10);
        @(negedge clk);
        drive32(2'b01, ra[1], rb[1], 5'd11);
        @(negedge clk);
        drive32(2'b10, ra[2], rb[2], 5'd12);
        #1;
        chk("stall_ready", 64'(a_ready), 64'd0);
        chk32("stall_head", 2'b00, ra[0], rb[0], 5'd10);
        held_res = a_res;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_hold_ready", 64'(a_ready), 64'd0);
            chk("stall_hold", {a_ov, a_otag, a_res}, {1'b1, 5'd10, held_res});
        end
        a_iready = 1;
        #1;
        chk("release_ready", 64'(a_ready), 64'd1);
        @(negedge clk);
        a_valid = 0;
        chk32("drain1", 2'b01, ra[1], rb[1], 5'd11);
        @(negedge clk);
        chk32("drain2", 2'b10, ra[2], rb[2], 5'd12);
        @(negedge clk);
        chk("drain_empty", 64'(a_ov), 64'd0);

        // ---- reset with two ops in flight ----
        drive32(2'b00, 32'd1, 32'd2, 5'd20);
        @(negedge clk);
        drive32(2'b00, 32'd3, 32'd4, 5'd21);
        @(negedge clk);
        a_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_ready", 64'(a_ready), 64'd0);
        @(negedge clk);
        rst_n = 1;
        chk("midrst_out", {27'd0, a_ov, a_res, a_flags}, 64'd0);
        chk("midrst_tag", 64'(a_otag), 64'd0);
        #1;
        chk("midrst_ready_after", 64'(a_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("midrst_no_stale", 64'(a_ov), 64'd0);
        end

        // ---- random traffic on 8-bit/4-stage instance ----
        sent = 0; got = 0; cyc = 0; hold = 0; hold_v = '{default: '0};
        while (got < NRND && cyc < 60000) begin
            r_valid  = (sent < NRND) && ($urandom_range(3) != 0);
            r_mode   = 2'($urandom);
            r_a      = 8'($urandom);
            r_b      = 8'($urandom);
            r_tag    = 4'($urandom);
            r_iready = ($urandom_range(3) != 0);
            #1;
            if (hold)
                chk("rnd_stable", {r_ov, r_res, r_flags, r_otag},
                    {1'b1, hold_v.res, hold_v.fl, hold_v.tag});
            chk("rnd_ready", 64'(r_ready), 64'(!(r_ov && !r_iready)));
            if (r_ov && r_iready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 64'(r_ov), 64'd0);
                end else begin
                    e8 = q.pop_front();
                    chk("rnd_result", {r_res, r_flags, r_otag}, {e8.res, e8.fl, e8.tag});
                end
                got++;
            end
            if (r_valid && r_ready) begin
                rr = model(W2, r_mode, u64_t'(r_a), u64_t'(r_b));
                q.push_back('{rr.res[W2-1:0], rr.fl, r_tag});
                sent++;
            end
            hold   = r_ov && !r_iready;
            hold_v = '{r_res, r_flags, r_otag};
            @(negedge clk);
            cyc++;
        end
        r_valid = 0;
        chk("rnd_count", 64'(got), 64'(NRND));
        chk("rnd_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
